// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch counter block.
package stopwatch_pkg;

  // Control states of the run/stop/lap/clear machine.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } sw_state_e;

  // Terminal values of the fixed-range digits (minutes is parameterised at the top).
  localparam int unsigned TENTHS_MAX   = 9;
  localparam int unsigned SEC_ONES_MAX = 9;
  localparam int unsigned SEC_TENS_MAX = 5;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Full M:SS.t time value, most significant digit first.
  typedef struct packed {
    bcd_t minutes;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t tenths;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the elapsed-time cascade: counts 0..MAX, wraps, and
// reports a combinational carry so digits can be chained.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output bcd_t value,
  output logic carry
);

  bcd_t value_q;
  bcd_t value_d;

  // Next digit value: clear has priority, otherwise step and wrap at MAX.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      if (value_q == bcd_t'(MAX)) begin
        value_d = '0;
      end else begin
        value_d = value_q + bcd_t'(1);
      end
    end
  end

  // Digit register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & (value_q == bcd_t'(MAX));

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch counter: button edge detection, run/stop/lap/clear control,
// a four-digit BCD M:SS.t live count, a lap snapshot, a sticky overflow
// flag and the display mux between live count and snapshot.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MINUTE_MAX = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic pulse,
  input  logic start_stop,
  input  logic lap_clear,
  output logic run,
  output bcd_t tenths,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t minutes,
  output logic lap_active,
  output logic overflow
);

  // Button history flops for rising-edge detection.
  logic ss_hist_q;
  logic lc_hist_q;
  logic ss_press;
  logic lc_press;

  sw_state_e state_q;
  sw_state_e state_d;

  bcd_time_t live;
  bcd_time_t snap_q;
  bcd_time_t snap_d;
  logic      overflow_q;
  logic      overflow_d;

  logic count_en;
  logic clear_cnt;
  logic take_snap;
  logic c_tenths;
  logic c_sec_ones;
  logic c_sec_tens;
  logic c_minutes;

  // A held button yields one press; start_stop wins over a coincident lap_clear.
  assign ss_press = start_stop & ~ss_hist_q;
  assign lc_press = lap_clear & ~lc_hist_q & ~ss_press;

  // Button history registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ss_hist_q <= 1'b0;
      lc_hist_q <= 1'b0;
    end else begin
      ss_hist_q <= start_stop;
      lc_hist_q <= lap_clear;
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic driven by the single-cycle press events.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ss_press) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ss_press)      state_d = ST_STOPPED;
        else if (lc_press) state_d = ST_LAP;
      end
      ST_STOPPED: begin
        if (ss_press)      state_d = ST_RUNNING;
        else if (lc_press) state_d = ST_IDLE;
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_STOPPED;
        else if (lc_press) state_d = ST_RUNNING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs and datapath controls; counting uses the pre-transition state.
  always_comb begin
    run        = 1'b0;
    lap_active = 1'b0;
    count_en   = 1'b0;
    clear_cnt  = 1'b0;
    take_snap  = 1'b0;
    unique case (state_q)
      ST_RUNNING: begin
        run       = 1'b1;
        count_en  = pulse;
        take_snap = lc_press;
      end
      ST_LAP: begin
        run        = 1'b1;
        lap_active = 1'b1;
        count_en   = pulse;
      end
      ST_STOPPED: begin
        clear_cnt = lc_press;
      end
      default: begin
      end
    endcase
  end

  bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
    .clock (clock),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (count_en),
    .value (live.tenths),
    .carry (c_tenths)
  );

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clock (clock),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (c_tenths),
    .value (live.sec_ones),
    .carry (c_sec_ones)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock (clock),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (c_sec_ones),
    .value (live.sec_tens),
    .carry (c_sec_tens)
  );

  bcd_digit #(.MAX(MINUTE_MAX)) u_minutes (
    .clock (clock),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (c_sec_tens),
    .value (live.minutes),
    .carry (c_minutes)
  );

  // Snapshot captures the registered (pre-increment) live count on RUNNING->LAP.
  always_comb begin
    snap_d = snap_q;
    if (clear_cnt) begin
      snap_d = '0;
    end else if (take_snap) begin
      snap_d = live;
    end
  end

  // Sticky overflow: set on a full wrap of the count, cleared only by clear or reset.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_cnt) begin
      overflow_d = 1'b0;
    end else if (c_minutes) begin
      overflow_d = 1'b1;
    end
  end

  // Snapshot and overflow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  // Display shows the frozen snapshot in LAP and the live count otherwise.
  always_comb begin
    if (state_q == ST_LAP) begin
      tenths   = snap_q.tenths;
      sec_ones = snap_q.sec_ones;
      sec_tens = snap_q.sec_tens;
      minutes  = snap_q.minutes;
    end else begin
      tenths   = live.tenths;
      sec_ones = live.sec_ones;
      sec_tens = live.sec_tens;
      minutes  = live.minutes;
    end
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

- Consumes the one-cycle `pulse` tick from the stopwatch timebase (10 Hz, one tick per tenth of a second).
- Owns the run/stop/lap/clear control state machine and drives `run` back to the timebase.
- Maintains a 4-digit BCD elapsed time, M:SS.t, and presents it to the display driver.
- Sits between the debounced button inputs, the pulse generator and the 7-segment display multiplexer.

## Interface
- `MINUTE_MAX`, default 9: terminal value of the minutes digit; legal range 1–9.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; while low, all state is forced to reset values.
- `pulse`  in  1  timebase tick, one cycle wide; only meaningful while `run` is high.
- `start_stop`  in  1  debounced, synchronous button level.
- `lap_clear`  in  1  debounced, synchronous button level.
- `run`  out  1  high in RUNNING and LAP; enables the pulse generator.
- `tenths`  out  4  displayed tenths digit, BCD 0–9.
- `sec_ones`  out  4  displayed seconds-units digit, BCD 0–9.
- `sec_tens`  out  4  displayed seconds-tens digit, BCD 0–5.
- `minutes`  out  4  displayed minutes digit, BCD 0–`MINUTE_MAX`.
- `lap_active`  out  1  high in LAP; the display is frozen.
- `overflow`  out  1  sticky; set when the count wraps.

## Operation
- **Button edges:** each button has a one-flop history register. `press = btn & ~btn_q`, one cycle per press. Holding a button produces a single event.
- **States:** IDLE, RUNNING, STOPPED, LAP.
- **`start_stop` press transitions:**
  - IDLE→RUNNING, RUNNING→STOPPED, STOPPED→RUNNING, LAP→STOPPED.
  - On LAP→STOPPED the display returns to the live count.
- **`lap_clear` press transitions:**
  - RUNNING→LAP: the live count is copied into the snapshot on that edge.
  - LAP→RUNNING: the display resumes the live count.
  - STOPPED→IDLE: the live count, the snapshot and `overflow` are cleared.
  - IDLE: no effect.
- **Simultaneous presses:** `start_stop` wins and the `lap_clear` press is discarded.
- **Counting:**
  - The live count advances by one tenth on any cycle where the current state is RUNNING or LAP and `pulse` is high.
  - The decision uses the pre-transition state, so a pulse coinciding with a stop press is still counted.
  - `pulse` is ignored in IDLE and STOPPED.
- **Cascade:**
  - tenths 9→0 carries into sec_ones.
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into minutes.
  - minutes `MINUTE_MAX`→0 sets `overflow`.
  - Counting continues after a wrap.
- **Display outputs:** show the snapshot in LAP and the live count in every other state. This is a combinational mux of registered values.
- **Snapshot timing:** when a RUNNING→LAP transition coincides with a pulse, the snapshot captures the pre-increment value.

## Timing
- **Reset values:** state IDLE; all digits 0; `run`=0, `lap_active`=0, `overflow`=0; both button history registers 0.
- **Control latency:** a button rising at edge k is sampled at edge k. The new state, `run` and `lap_active` are visible after edge k, i.e. one cycle of latency.
- **Count latency:** a `pulse` sampled at edge k updates the digits after edge k.
- **Reset mid-count:** asserting `reset` in any state returns to reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- **Overflow:** `overflow` is set on the edge that wraps `MINUTE_MAX`:5:9.9 to 0:00.0. It clears only on STOPPED→IDLE or on `reset`.

## Structure
- **Package `stopwatch_pkg`:**
  - state enum;
  - `TENTHS_MAX`=9, `SEC_ONES_MAX`=9, `SEC_TENS_MAX`=5;
  - BCD digit type (4 bits).
- **Sub-module `bcd_digit`:** parameter `MAX`; ports `clock`, `reset`, `clear`, `inc`, `value[3:0]`, `carry`.
  - `carry` = `inc & (value==MAX)`, combinational.
  - Instantiated four times, with each digit's `carry` driving the next digit's `inc`.
- **Top level:** edge detectors, state register, snapshot registers, overflow flag and display mux.

## Test plan
- **Reset and start:**
  - Stimulus: reset low for 2 cycles, release, press `start_stop`, then 25 pulses.
  - Required: `run`=1 one cycle after the press; display 0:02.5.
- **Stop and resume:**
  - Stimulus: after 9 pulses press `start_stop`, apply 5 pulses, press again, apply 3 pulses.
  - Required: display 0:01.2; stopped-state pulses are ignored.
- **Lap:**
  - Stimulus: RUNNING at 0:00.7, press `lap_clear`, apply 20 pulses.
  - Required: display holds 0:00.7 with `lap_active`=1.
  - Then press `lap_clear` again. Required: display 0:02.7.
- **Cascade and overflow:**
  - Stimulus: `MINUTE_MAX`=1, run 1200 pulses.
  - Required: display passes 0:59.9→1:00.0, then 1:59.9→0:00.0 with `overflow`=1.
  - Then stop and press `lap_clear`. Required: all digits 0, `overflow`=0.
- **Simultaneous events:**
  - Stimulus: press both buttons together while RUNNING.
  - Required: STOPPED, `lap_active`=0.
  - Stimulus: pulse on the same cycle as a stop press at 0:00.3. Required: display 0:00.4.
- **Asynchronous reset:**
  - Stimulus: assert `reset` mid-clock-period in LAP at 0:03.1.
  - Required: outputs reach reset values before the next clock edge.
